player_collision: RTL and testbench
===================================

# player_collision

Per-frame collision and lives tracker for the player sprite. Sits directly downstream of `player`'s hitbox stage. Each clock it samples the per-pixel player-hitbox flag against the per-pixel obstacle flag as the OLED driver sweeps `pixel_index`. At every frame wrap it decides whether a hit occurred, then updates lives, invulnerability and game-over state for the game controller and display mux.

## Interface
Parameters:
- `LIVES_INIT`, default 3: lives loaded at game start; range 1–7.
- `IFRAMES`, default 60: invulnerability length in frames after a hit; range 1–255.
- `MIN_OVERLAP`, default 1: overlapping pixels per frame needed to count a hit; range 1–255.
- `BLINK_SHIFT`, default 2: during invulnerability, `player_visible` toggles every 2^BLINK_SHIFT frames.

Ports:
- `clock_100mhz`  in  1: single system clock; all state on its rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `pixel_index`  in  13: current OLED pixel, range 0..6143, held for many clocks per pixel.
- `is_player_hitbox`  in  1: combinational from `pixel_index`; pixel is inside the player hitbox.
- `is_obstacle`  in  1: combinational from `pixel_index`; pixel is inside any obstacle.
- `game_active`  in  1: level signal from the game controller.
- `collision_pulse`  out  1: one-cycle strobe per accepted hit.
- `lives`  out  3: remaining lives.
- `invulnerable`  out  1: high while hits are ignored.
- `player_visible`  out  1: display gating for the blink effect.
- `game_over`  out  1: sticky until `game_active` falls.

## Operation
- `pixel_index_q` is a register holding the previous `pixel_index`. `new_pixel` = (`pixel_index` != `pixel_index_q`).
- `frame_end` = `new_pixel` && (`pixel_index` < `pixel_index_q`), i.e. a wrap.
- On a `new_pixel` cycle:
  - if `is_player_hitbox & is_obstacle`, `overlap_cnt` increments, saturating at 255;
  - on a `frame_end` cycle the sample counts toward the new frame.
- At `frame_end`:
  - `hit` = (`overlap_cnt` >= `MIN_OVERLAP`), evaluated on the old frame's count;
  - `overlap_cnt` restarts at 0 (or 1 if the wrap-cycle sample overlaps).
- FSM states: IDLE, PLAY, INVULN, OVER.
  - IDLE → PLAY on `game_active` high. `lives` = `LIVES_INIT`.
  - PLAY → INVULN on `frame_end` && `hit` && `lives` > 1. Assert `collision_pulse`, decrement `lives`, set `iframe_cnt` = `IFRAMES`.
  - PLAY → OVER on `frame_end` && `hit` && `lives` == 1. Assert `collision_pulse`; `lives` becomes 0.
  - INVULN: `iframe_cnt` decrements on each `frame_end`, and `hit` is ignored. On the `frame_end` where `iframe_cnt` == 1, go to PLAY. A hit on that same frame is also ignored.
  - OVER holds until `game_active` is low.
  - Any state → IDLE when `game_active` is low. This takes priority over every other transition. In IDLE, `lives`, `iframe_cnt` and `overlap_cnt` are held at 0.
- `player_visible`:
  - 1 outside INVULN;
  - in INVULN, equal to NOT bit `BLINK_SHIFT` of the `blink_cnt` frame counter, which is zeroed on INVULN entry.
- `invulnerable` = (state == INVULN). `game_over` = (state == OVER).

## Timing
- Reset values:
  - all outputs 0 except `player_visible` = 1;
  - state IDLE;
  - `pixel_index_q` = 0, so an index already nonzero at reset release counts as a `new_pixel` but not a wrap.
- Latency: the `frame_end` cycle registers the decision. `collision_pulse`, `lives`, `invulnerable` and `game_over` change on the next rising edge. `collision_pulse` is high exactly one cycle.
- At most one hit per frame. A frame's overlap affects only that frame's decision.
- `game_active` is sampled every cycle. Going low mid-frame discards the partial `overlap_cnt`. The first decision after re-entering PLAY uses a partial frame; this is intended.
- Async reset mid-frame: state is cleared immediately, and the next wrap after release is handled as a normal `frame_end`.

## Structure
- Shared package `game_pkg` holds:
  - `OLED_W` = 96, `OLED_H` = 64, `PIXEL_COUNT` = 6144, `PIXEL_IDX_W` = 13;
  - the state encoding (IDLE=0, PLAY=1, INVULN=2, OVER=3).
- One sub-module, `pixel_frame_tracker`: it registers `pixel_index` and outputs `new_pixel` and `frame_end`. Obstacle and other per-frame blocks reuse it.
- The top level contains the overlap counter, the FSM, the iframe/blink counters and the output registers.

## Test plan
- Reset, `game_active` = 1, no overlap for 3 frames → `lives` = 3, `collision_pulse` never high, `player_visible` = 1.
- Overlap at 1 pixel (index 1000) in frame 2 → one-cycle `collision_pulse` one cycle after the wrap; `lives` 3 → 2; `invulnerable` = 1 for exactly 60 frame_ends.
- Overlap every frame, `IFRAMES` = 2 → pulses on frames 1, 4 and 7; `lives` goes 2, 1, 0; `game_over` = 1 after the third pulse and stays 1 with no further pulses.
- `MIN_OVERLAP` = 5, 4 overlapping pixels → no hit; 5 pixels → hit. Each pixel is held for 16 clocks and counted once.
- `game_active` dropped mid-INVULN → IDLE next cycle: `lives` = 0, `invulnerable` = 0. Raising it again → `lives` = 3.
- Async `reset` pulsed mid-frame in OVER → outputs cleared without a clock edge; the next wrap is handled normally.

Source files
------------

// File: rtl/game_pkg.sv
// Shared OLED geometry and game-state encoding used by the per-frame game blocks.
package game_pkg;

  localparam int OLED_W      = 96;
  localparam int OLED_H      = 64;
  localparam int PIXEL_COUNT = OLED_W * OLED_H;
  localparam int PIXEL_IDX_W = 13;

  // Width of the per-frame overlap counter; it saturates at its all-ones value.
  localparam int OVERLAP_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    INVULN = 2'd2,
    OVER   = 2'd3
  } player_state_t;

endpackage

// File: rtl/pixel_frame_tracker.sv
// Registers the OLED sweep index and flags the first cycle of each new pixel
// and the wrap back to the start of a frame.
module pixel_frame_tracker
  import game_pkg::*;
(
  input  logic                   clock_100mhz,
  input  logic                   reset,
  input  logic [PIXEL_IDX_W-1:0] pixel_index,
  output logic                   new_pixel,
  output logic                   frame_end
);

  logic [PIXEL_IDX_W-1:0] pixel_index_q;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clock_100mhz or posedge reset) begin
    if (reset) pixel_index_q <= '0;
    else       pixel_index_q <= pixel_index;
  end

  assign new_pixel = (pixel_index != pixel_index_q);
  assign frame_end = new_pixel && (pixel_index < pixel_index_q);

endmodule

// File: rtl/player_collision.sv
// Per-frame player/obstacle overlap detection with lives, invulnerability,
// blink and game-over tracking for the game controller and display mux.
module player_collision
  import game_pkg::*;
#(
  parameter int LIVES_INIT  = 3,
  parameter int IFRAMES     = 60,
  parameter int MIN_OVERLAP = 1,
  parameter int BLINK_SHIFT = 2
) (
  input  logic                   clock_100mhz,
  input  logic                   reset,
  input  logic [PIXEL_IDX_W-1:0] pixel_index,
  input  logic                   is_player_hitbox,
  input  logic                   is_obstacle,
  input  logic                   game_active,
  output logic                   collision_pulse,
  output logic [2:0]             lives,
  output logic                   invulnerable,
  output logic                   player_visible,
  output logic                   game_over
);

  localparam logic [2:0]           LIVES_LOAD  = 3'(LIVES_INIT);
  localparam logic [7:0]           IFRAME_LOAD = 8'(IFRAMES);
  localparam logic [OVERLAP_W-1:0] OVERLAP_MIN = OVERLAP_W'(MIN_OVERLAP);
  localparam int                   BLINK_W     = BLINK_SHIFT + 1;

  logic new_pixel;
  logic frame_end;

  pixel_frame_tracker u_tracker (
    .clock_100mhz (clock_100mhz),
    .reset        (reset),
    .pixel_index  (pixel_index),
    .new_pixel    (new_pixel),
    .frame_end    (frame_end)
  );

  player_state_t        state_q, state_d;
  logic [OVERLAP_W-1:0] overlap_cnt;
  logic [7:0]           iframe_cnt_q, iframe_cnt_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic [2:0]           lives_q, lives_d;
  logic                 pulse_q, pulse_d;
  logic                 overlap_now;
  logic                 hit;

  // Each pixel is held for many clocks; only its first cycle is sampled.
  assign overlap_now = new_pixel && is_player_hitbox && is_obstacle;
  assign hit         = (overlap_cnt >= OVERLAP_MIN);

  // The wrap-cycle sample belongs to the new frame, so it seeds the restarted count.
  always_ff @(posedge clock_100mhz or posedge reset) begin
    if (reset) begin
      overlap_cnt <= '0;
    end else if (!game_active || state_q == IDLE) begin
      overlap_cnt <= '0;
    end else if (frame_end) begin
      overlap_cnt <= OVERLAP_W'(overlap_now);
    end else if (overlap_now && overlap_cnt != '1) begin
      overlap_cnt <= overlap_cnt + OVERLAP_W'(1);
    end
  end

  always_ff @(posedge clock_100mhz or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      lives_q      <= '0;
      iframe_cnt_q <= '0;
      blink_cnt_q  <= '0;
      pulse_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      iframe_cnt_q <= iframe_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      pulse_q      <= pulse_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so no
    // path leaves a variable unassigned and no latch is inferred.
    state_d      = state_q;
    lives_d      = lives_q;
    iframe_cnt_d = iframe_cnt_q;
    blink_cnt_d  = blink_cnt_q;
    pulse_d      = 1'b0;

    if (!game_active) begin
      state_d      = IDLE;
      lives_d      = '0;
      iframe_cnt_d = '0;
      blink_cnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = PLAY;
          lives_d = LIVES_LOAD;
        end
        PLAY: begin
          if (frame_end && hit) begin
            pulse_d = 1'b1;
            if (lives_q > 3'd1) begin
              state_d      = INVULN;
              lives_d      = lives_q - 3'd1;
              iframe_cnt_d = IFRAME_LOAD;
              blink_cnt_d  = '0;
            end else begin
              state_d = OVER;
              lives_d = '0;
            end
          end
        end
        INVULN: begin
          // Hits are ignored here, including on the frame that ends invulnerability.
          if (frame_end) begin
            blink_cnt_d  = blink_cnt_q + BLINK_W'(1);
            iframe_cnt_d = iframe_cnt_q - 8'd1;
            if (iframe_cnt_q == 8'd1) state_d = PLAY;
          end
        end
        OVER: begin
          state_d = OVER;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign collision_pulse = pulse_q;
  assign lives           = lives_q;
  assign invulnerable    = (state_q == INVULN);
  assign game_over       = (state_q == OVER);
  assign player_visible  = (state_q != INVULN) || !blink_cnt_q[BLINK_SHIFT];

endmodule

// File: tb/tb_player_collision.sv
// Scoreboard bench for player_collision: directed frames push expected hits,
// a negedge monitor pops and checks them whenever a collision pulse appears.
module tb_player_collision;
  import game_pkg::*;

  logic                   clock_100mhz = 1'b0;
  logic                   reset = 1'b1;
  logic [PIXEL_IDX_W-1:0] pixel_index = '0;
  logic                   is_player_hitbox = 1'b0;
  logic                   is_obstacle = 1'b0;
  logic                   game_active_a = 1'b0;
  logic                   game_active_b = 1'b0;

  logic       collision_pulse_a, invulnerable_a, player_visible_a, game_over_a;
  logic       collision_pulse_b, invulnerable_b, player_visible_b, game_over_b;
  logic [2:0] lives_a, lives_b;

  typedef struct {
    int cyc;
    int lives;
    int over;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clock_100mhz = ~clock_100mhz;
  always @(posedge clock_100mhz) cyc <= cyc + 1;

  // Default parameters: 3 lives, 60 iframes, 1 pixel overlap, blink every 4 frames.
  player_collision u_dut_a (
    .clock_100mhz     (clock_100mhz),
    .reset            (reset),
    .pixel_index      (pixel_index),
    .is_player_hitbox (is_player_hitbox),
    .is_obstacle      (is_obstacle),
    .game_active      (game_active_a),
    .collision_pulse  (collision_pulse_a),
    .lives            (lives_a),
    .invulnerable     (invulnerable_a),
    .player_visible   (player_visible_a),
    .game_over        (game_over_a)
  );

  // Short invulnerability, 5-pixel overlap threshold, blink every frame.
  player_collision #(
    .LIVES_INIT  (3),
    .IFRAMES     (2),
    .MIN_OVERLAP (5),
    .BLINK_SHIFT (0)
  ) u_dut_b (
    .clock_100mhz     (clock_100mhz),
    .reset            (reset),
    .pixel_index      (pixel_index),
    .is_player_hitbox (is_player_hitbox),
    .is_obstacle      (is_obstacle),
    .game_active      (game_active_b),
    .collision_pulse  (collision_pulse_b),
    .lives            (lives_b),
    .invulnerable     (invulnerable_b),
    .player_visible   (player_visible_b),
    .game_over        (game_over_b)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_outputs(input string tag, input bit sel, input int exp_lives,
                               input int exp_inv, input int exp_vis, input int exp_over);
    check({tag, " lives"},          sel ? int'(lives_b) : int'(lives_a), exp_lives);
    check({tag, " invulnerable"},   sel ? int'(invulnerable_b) : int'(invulnerable_a), exp_inv);
    check({tag, " player_visible"}, sel ? int'(player_visible_b) : int'(player_visible_a), exp_vis);
    check({tag, " game_over"},      sel ? int'(game_over_b) : int'(game_over_a), exp_over);
  endtask

  // Frame layout: pixel k sits at index k*200 (k = 1..30), wrap pixel at index 0.
  // Hitbox covers k = 5..12, obstacles cover k = 1..4+n_ov, so exactly n_ov pixels
  // overlap, starting at index 1000.
  task automatic drive_pixel(input int k, input int n_ov, input int hold);
    pixel_index      = PIXEL_IDX_W'(k * 200);
    is_player_hitbox = (k >= 5 && k < 13);
    is_obstacle      = (k >= 1 && k < 5 + n_ov);
    repeat (hold) begin
      @(posedge clock_100mhz);
      #1;
    end
  endtask

  task automatic run_frame(input string tag, input bit sel, input int start_k, input int n_ov,
                           input int hold, input bit exp_pulse, input int exp_lives,
                           input int exp_inv, input int exp_vis, input int exp_over);
    exp_t e;
    for (int k = start_k; k <= 30; k++) drive_pixel(k, n_ov, hold);
    if (exp_pulse) begin
      e.cyc   = cyc + 1;
      e.lives = exp_lives;
      e.over  = exp_over;
      if (sel) q_b.push_back(e);
      else     q_a.push_back(e);
    end
    drive_pixel(0, 0, hold);
    check({tag, " pulse seen"}, sel ? q_b.size() : q_a.size(), 0);
    check_outputs(tag, sel, exp_lives, exp_inv, exp_vis, exp_over);
  endtask

  task automatic monitor();
    bit   prev_a = 1'b0;
    bit   prev_b = 1'b0;
    exp_t e;
    forever begin
      @(negedge clock_100mhz);
      if (reset) begin
        prev_a = 1'b0;
        prev_b = 1'b0;
      end else begin
        if (collision_pulse_a) begin
          check("a pulse one cycle", int'(prev_a), 0);
          if (q_a.size() == 0) begin
            check("a pulse unexpected", int'(collision_pulse_a), 0);
          end else begin
            e = q_a.pop_front();
            check("a pulse cycle", cyc, e.cyc);
            check("a pulse lives", int'(lives_a), e.lives);
            check("a pulse game_over", int'(game_over_a), e.over);
          end
        end
        if (collision_pulse_b) begin
          check("b pulse one cycle", int'(prev_b), 0);
          if (q_b.size() == 0) begin
            check("b pulse unexpected", int'(collision_pulse_b), 0);
          end else begin
            e = q_b.pop_front();
            check("b pulse cycle", cyc, e.cyc);
            check("b pulse lives", int'(lives_b), e.lives);
            check("b pulse game_over", int'(game_over_b), e.over);
          end
        end
        prev_a = collision_pulse_a;
        prev_b = collision_pulse_b;
      end
    end
  endtask

  initial begin
    fork
      monitor();
      begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset with game_active already high must hold everything cleared.
    game_active_a = 1'b1;
    repeat (3) @(posedge clock_100mhz);
    #1;
    check("reset a pulse", int'(collision_pulse_a), 0);
    check_outputs("reset a", 1'b0, 0, 0, 1, 0);
    check_outputs("reset b", 1'b1, 0, 0, 1, 0);
    reset = 1'b0;
    @(posedge clock_100mhz);
    #1;
    check_outputs("start a", 1'b0, 3, 0, 1, 0);

    // Three clean frames, then one pixel of overlap at index 1000.
    for (int f = 1; f <= 3; f++)
      run_frame($sformatf("a clean f%0d", f), 1'b0, 1, 0, 2, 1'b0, 3, 0, 1, 0);
    run_frame("a hit1", 1'b0, 1, 1, 2, 1'b1, 2, 1, 1, 0);

    // Exactly 60 frame_ends of invulnerability; overlap every frame is ignored.
    for (int i = 1; i <= 60; i++)
      run_frame($sformatf("a invuln f%0d", i), 1'b0, 1, 1, 2, 1'b0, 2,
                (i < 60) ? 1 : 0, (i >= 60) ? 1 : (((i >> 2) & 1) == 0 ? 1 : 0), 0);

    run_frame("a hit2", 1'b0, 1, 1, 2, 1'b1, 1, 1, 1, 0);
    run_frame("a invuln2 f1", 1'b0, 1, 0, 2, 1'b0, 1, 1, 1, 0);

    // Drop game_active mid-frame after an overlapping pixel, then re-enter play.
    for (int k = 1; k <= 7; k++) drive_pixel(k, 1, 2);
    game_active_a = 1'b0;
    @(posedge clock_100mhz);
    #1;
    check_outputs("a drop", 1'b0, 0, 0, 1, 0);
    game_active_a = 1'b1;
    @(posedge clock_100mhz);
    #1;
    check_outputs("a rejoin", 1'b0, 3, 0, 1, 0);
    run_frame("a partial", 1'b0, 8, 0, 2, 1'b0, 3, 0, 1, 0);
    game_active_a = 1'b0;

    // Overlap threshold of 5 with each pixel held 16 clocks.
    game_active_b = 1'b1;
    @(posedge clock_100mhz);
    #1;
    check_outputs("b start", 1'b1, 3, 0, 1, 0);
    run_frame("b four px", 1'b1, 1, 4, 16, 1'b0, 3, 0, 1, 0);
    run_frame("b five px", 1'b1, 1, 5, 16, 1'b1, 2, 1, 1, 0);

    // Restart, then overlap every frame with a 2-frame invulnerability window.
    game_active_b = 1'b0;
    repeat (2) @(posedge clock_100mhz);
    #1;
    check_outputs("b idle", 1'b1, 0, 0, 1, 0);
    game_active_b = 1'b1;
    @(posedge clock_100mhz);
    #1;
    run_frame("b f1", 1'b1, 1, 5, 2, 1'b1, 2, 1, 1, 0);
    run_frame("b f2", 1'b1, 1, 5, 2, 1'b0, 2, 1, 0, 0);
    run_frame("b f3", 1'b1, 1, 5, 2, 1'b0, 2, 0, 1, 0);
    run_frame("b f4", 1'b1, 1, 5, 2, 1'b1, 1, 1, 1, 0);
    run_frame("b f5", 1'b1, 1, 5, 2, 1'b0, 1, 1, 0, 0);
    run_frame("b f6", 1'b1, 1, 5, 2, 1'b0, 1, 0, 1, 0);
    run_frame("b f7", 1'b1, 1, 5, 2, 1'b1, 0, 0, 1, 1);
    run_frame("b f8", 1'b1, 1, 5, 2, 1'b0, 0, 0, 1, 1);
    run_frame("b f9", 1'b1, 1, 5, 2, 1'b0, 0, 0, 1, 1);

    // Asynchronous reset mid-frame while in OVER, checked before any clock edge.
    for (int k = 1; k <= 3; k++) drive_pixel(k, 5, 2);
    #2;
    reset = 1'b1;
    #1;
    check("b async reset pulse", int'(collision_pulse_b), 0);
    check_outputs("b async reset", 1'b1, 0, 0, 1, 0);
    @(posedge clock_100mhz);
    #1;
    reset = 1'b0;
    run_frame("b after reset", 1'b1, 4, 5, 2, 1'b1, 2, 1, 1, 0);

    repeat (4) @(posedge clock_100mhz);
    #1;
    check("a queue drained", q_a.size(), 0);
    check("b queue drained", q_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
